// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit: per-beat AND/OR/XOR/NOR/ANDN plus multi-beat AND/OR
// accumulate bursts, two register stages with valid/ready handshakes on both sides.

package logic_unit_pkg;
    typedef enum logic [2:0] {
        OP_AND     = 3'b000,
        OP_OR      = 3'b001,
        OP_XOR     = 3'b010,
        OP_NOR     = 3'b011,
        OP_ANDN    = 3'b100,
        OP_ACC_AND = 3'b101,
        OP_ACC_OR  = 3'b110,
        OP_RSVD    = 3'b111
    } op_e;
endpackage

// One bit of the datapath. For ACC ops the result is also the next accumulator bit.
module logic_unit_lane
    import logic_unit_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic [2:0] op,
    input  logic       acc,
    input  logic       acc_active,
    output logic       res
);
    logic v;

    always_comb begin
        v   = 1'b0;
        res = 1'b0;
        case (op)
            OP_AND:     res = a & b;
            OP_OR:      res = a | b;
            OP_XOR:     res = a ^ b;
            OP_NOR:     res = ~(a | b);
            OP_ANDN:    res = a & ~b;
            OP_ACC_AND: begin
                v   = a & b;
                res = acc_active ? (acc & v) : v;
            end
            OP_ACC_OR:  begin
                v   = a | b;
                res = acc_active ? (acc | v) : v;
            end
            default:    res = 1'b0;
        endcase
    end
endmodule

module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_err
);
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [2:0]       op;
        logic             last;
    } beat_t;

    // vld_pipe[1] = S1 occupied, vld_pipe[2] = S2 occupied (drives out_valid)
    logic [2:1]       vld_pipe;
    beat_t            s1;
    beat_t            req;
    logic             rdy_en;
    logic [WIDTH-1:0] acc;
    logic             acc_active;
    logic [WIDTH-1:0] res;

    logic s2_stall, s1_open, s1_adv, in_fire;
    logic is_acc, emit, is_rsvd;

    assign req       = '{a: in_a, b: in_b, op: in_op, last: in_last};
    assign s2_stall  = vld_pipe[2] & ~out_ready;
    assign s1_open   = ~vld_pipe[1] | ~s2_stall;
    assign s1_adv    = vld_pipe[1] & ~s2_stall;
    // rdy_en keeps in_ready low until the first edge after reset release
    assign in_ready  = rdy_en & s1_open;
    assign in_fire   = in_valid & in_ready;
    assign out_valid = vld_pipe[2];

    assign is_acc  = (s1.op == OP_ACC_AND) | (s1.op == OP_ACC_OR);
    assign is_rsvd = (s1.op == OP_RSVD);
    // non-final ACC beats fold into acc and produce no output
    assign emit    = ~is_acc | s1.last;

    for (genvar g = 0; g < WIDTH; g++) begin : g_lane
        logic_unit_lane u_lane (
            .a          (s1.a[g]),
            .b          (s1.b[g]),
            .op         (s1.op),
            .acc        (acc[g]),
            .acc_active (acc_active),
            .res        (res[g])
        );
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe[1] <= 1'b0;
            s1          <= '0;
        end else if (s1_open) begin
            vld_pipe[1] <= in_fire;
            if (in_fire) s1 <= req;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe[2] <= 1'b0;
            out_data    <= '0;
            out_zero    <= 1'b0;
            out_err     <= 1'b0;
        end else if (!s2_stall) begin
            vld_pipe[2] <= s1_adv & emit;
            if (s1_adv & emit) begin
                out_data <= res;
                out_zero <= ~|res;
                out_err  <= is_rsvd;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc        <= '0;
            acc_active <= 1'b0;
        end else if (s1_adv & is_acc) begin
            if (s1.last) begin
                acc        <= '0;
                acc_active <= 1'b0;
            end else begin
                acc        <= res;
                acc_active <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_logic_unit_pipe.sv
// Randomised and directed bench for logic_unit_pipe against a queue-based reference model.

module tb_logic_unit_pipe;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready, in_last, out_valid, out_ready, out_zero, out_err;
    logic [31:0] in_a, in_b, out_data;
    logic [2:0]  in_op;

    logic        v8, rdy8, ov8, z8, e8;
    logic [7:0]  a8, b8, d8;
    logic        v64, rdy64, ov64, z64, e64;
    logic [63:0] a64, b64, d64;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [31:0] got_d[$];
    bit          got_z[$];
    bit          got_e[$];
    int          got_c[$];

    logic [31:0] exp_d[$];
    bit          exp_e[$];
    logic [31:0] m_acc;
    bit          m_act;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    logic_unit_pipe #(.WIDTH(32)) dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_zero(out_zero), .out_err(out_err));

    logic_unit_pipe #(.WIDTH(8)) dut8 (
        .clock(clock), .reset_n(reset_n), .in_valid(v8), .in_ready(rdy8),
        .in_a(a8), .in_b(b8), .in_op(3'b000), .in_last(1'b0),
        .out_valid(ov8), .out_ready(1'b1), .out_data(d8),
        .out_zero(z8), .out_err(e8));

    logic_unit_pipe #(.WIDTH(64)) dut64 (
        .clock(clock), .reset_n(reset_n), .in_valid(v64), .in_ready(rdy64),
        .in_a(a64), .in_b(b64), .in_op(3'b000), .in_last(1'b0),
        .out_valid(ov64), .out_ready(1'b1), .out_data(d64),
        .out_zero(z64), .out_err(e64));

    // Record every completed output transfer with the cycle it was seen.
    always @(negedge clock) begin
        if (reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            got_d.push_back(out_data);
            got_z.push_back(out_zero);
            got_e.push_back(out_err);
            got_c.push_back(cyc);
        end
    end

    // Reference: each accepted beat in order, ACC folding done with plain arithmetic.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input logic [2:0] op, input bit last);
        logic [31:0] v;
        case (op)
            3'd0: begin exp_d.push_back(a & b);    exp_e.push_back(1'b0); end
            3'd1: begin exp_d.push_back(a | b);    exp_e.push_back(1'b0); end
            3'd2: begin exp_d.push_back(a ^ b);    exp_e.push_back(1'b0); end
            3'd3: begin exp_d.push_back(~(a | b)); exp_e.push_back(1'b0); end
            3'd4: begin exp_d.push_back(a & ~b);   exp_e.push_back(1'b0); end
            3'd7: begin exp_d.push_back(32'd0);    exp_e.push_back(1'b1); end
            default: begin
                v = (op == 3'd5) ? (a & b) : (a | b);
                if (m_act) v = (op == 3'd5) ? (m_acc & v) : (m_acc | v);
                if (last) begin
                    exp_d.push_back(v); exp_e.push_back(1'b0);
                    m_acc = 32'd0; m_act = 1'b0;
                end else begin
                    m_acc = v; m_act = 1'b1;
                end
            end
        endcase
    endfunction

    task automatic step();
        @(posedge clock); #1;
    endtask

    task automatic clear_got();
        got_d.delete(); got_z.delete(); got_e.delete(); got_c.delete();
    endtask

    // Present a beat and return just after the edge that accepts it; in_valid is left high.
    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input bit last);
        in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_last = last;
        for (int k = 0; k < 50; k++) begin
            @(negedge clock);
            if (in_ready === 1'b1) break;
        end
        if (in_ready !== 1'b1) begin
            checks++; failures++;
            $display("FAIL send_timeout in_ready=%b required 1", in_ready);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
        checks++; if (out_data !== 32'd0) begin failures++; $display("FAIL rst_out_data got %h want 0", out_data); end
        checks++; if ({out_zero, out_err} !== 2'b00) begin failures++; $display("FAIL rst_flags got %b want 00", {out_zero, out_err}); end
        reset_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rel_in_ready_pre got %b want 0", in_ready); end
        step();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rel_in_ready_post got %b want 1", in_ready); end
    endtask

    task automatic test_and();
        int n0;
        out_ready = 1'b1;
        clear_got();
        n0 = cyc;
        send(32'hFFFF0000, 32'h0F0F0F0F, 3'd0, 1'b0);
        in_valid = 1'b0;
        repeat (4) step();
        checks++;
        if (got_d.size() != 1) begin
            failures++; $display("FAIL and_count got %0d want 1", got_d.size());
        end else begin
            checks++; if (got_d[0] !== 32'h0F0F0000) begin failures++; $display("FAIL and_data got %h want 0f0f0000", got_d[0]); end
            checks++; if ({got_z[0], got_e[0]} !== 2'b00) begin failures++; $display("FAIL and_flags got %b want 00", {got_z[0], got_e[0]}); end
            checks++; if (got_c[0] != n0 + 2) begin failures++; $display("FAIL and_latency got %0d want %0d", got_c[0] - n0, 2); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] want [4];
        want[0] = 32'hA5A5FFFF; want[1] = 32'hA5A55A5A;
        want[2] = 32'h5A5A0000; want[3] = 32'hA5A50000;
        out_ready = 1'b1;
        clear_got();
        for (int i = 0; i < 4; i++) send(32'hA5A5A5A5, 32'h0000FFFF, 3'(i + 1), 1'b0);
        in_valid = 1'b0;
        repeat (4) step();
        checks++;
        if (got_d.size() != 4) begin
            failures++; $display("FAIL b2b_count got %0d want 4", got_d.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_d[i] !== want[i] || got_c[i] != got_c[0] + i) begin
                    failures++;
                    $display("FAIL b2b_beat%0d got %h@%0d want %h@%0d", i, got_d[i], got_c[i], want[i], got_c[0] + i);
                end
            end
        end
    endtask

    task automatic test_acc();
        out_ready = 1'b1;
        clear_got();
        send(32'hF0F0F0F0, 32'hFFFFFFFF, 3'd5, 1'b0);
        send(32'hFF00FF00, 32'hFFFFFFFF, 3'd5, 1'b0);
        send(32'hF000F000, 32'hFFFFFFFF, 3'd5, 1'b1);
        send(32'h00000001, 32'h00000000, 3'd6, 1'b1);
        in_valid = 1'b0;
        repeat (6) step();
        checks++;
        if (got_d.size() != 2) begin
            failures++; $display("FAIL acc_count got %0d want 2", got_d.size());
        end else begin
            checks++; if (got_d[0] !== 32'hF000F000) begin failures++; $display("FAIL acc_and got %h want f000f000", got_d[0]); end
            checks++; if (got_d[1] !== 32'h00000001 || got_e[1] !== 1'b0) begin failures++; $display("FAIL acc_or_single got %h err=%b want 00000001 err=0", got_d[1], got_e[1]); end
        end
    endtask

    task automatic test_random();
        logic [31:0] pa, pb, hd, ed;
        logic [2:0]  pop;
        bit          pl, pend, pstall, hz, he, ee;
        int          sent;
        for (int r = 0; r < 3; r++) begin
            sent = 0; pend = 1'b0; pstall = 1'b0;
            exp_d.delete(); exp_e.delete();
            m_acc = 32'd0; m_act = 1'b0;
            pa = 0; pb = 0; pop = 0; pl = 0; hd = 0; hz = 0; he = 0;
            for (int c = 0; c < 400; c++) begin
                out_ready = (c % 3 == 0);
                if (!pend && sent < 8 && ($urandom % 4 != 0)) begin
                    pa = $urandom; pb = $urandom; pop = 3'($urandom_range(0, 7)); pl = $urandom % 2;
                    if (sent == 7 && (pop == 3'd5 || pop == 3'd6)) pl = 1'b1;
                    pend = 1'b1;
                    in_a = pa; in_b = pb; in_op = pop; in_last = pl;
                end
                in_valid = pend;
                @(negedge clock);
                if (pstall) begin
                    checks++;
                    if (out_valid !== 1'b1 || out_data !== hd || out_zero !== hz || out_err !== he) begin
                        failures++;
                        $display("FAIL rnd_hold got v=%b %h z=%b e=%b want v=1 %h z=%b e=%b", out_valid, out_data, out_zero, out_err, hd, hz, he);
                    end
                end
                checks++;
                if (!(out_valid && !out_ready) && in_ready !== 1'b1) begin
                    failures++; $display("FAIL rnd_in_ready got %b want 1 (no stall)", in_ready);
                end
                if (in_valid && in_ready) begin
                    model(pa, pb, pop, pl);
                    sent++; pend = 1'b0;
                end
                if (out_valid && out_ready) begin
                    checks++;
                    if (exp_d.size() == 0) begin
                        failures++; $display("FAIL rnd_extra got %h want no output", out_data);
                    end else begin
                        ed = exp_d.pop_front(); ee = exp_e.pop_front();
                        if (out_data !== ed || out_zero !== (ed == 32'd0) || out_err !== ee) begin
                            failures++;
                            $display("FAIL rnd_data got %h z=%b e=%b want %h z=%b e=%b", out_data, out_zero, out_err, ed, (ed == 32'd0), ee);
                        end
                    end
                end
                pstall = out_valid && !out_ready;
                hd = out_data; hz = out_zero; he = out_err;
                @(posedge clock); #1;
                if (sent == 8 && !pend && exp_d.size() == 0) break;
            end
            in_valid = 1'b0;
            checks++;
            if (sent != 8 || exp_d.size() != 0) begin
                failures++; $display("FAIL rnd_drain sent=%0d pending=%0d want sent=8 pending=0", sent, exp_d.size());
            end
        end
        out_ready = 1'b1;
        repeat (3) step();
    endtask

    task automatic test_flags();
        out_ready = 1'b1;
        clear_got();
        send($urandom, $urandom, 3'd7, 1'b0);
        send(32'h1, 32'h2, 3'd0, 1'b0);
        in_valid = 1'b0;
        repeat (4) step();
        checks++;
        if (got_d.size() != 2) begin
            failures++; $display("FAIL flags_count got %0d want 2", got_d.size());
        end else begin
            checks++; if ({got_d[0], got_z[0], got_e[0]} !== {32'd0, 2'b11}) begin failures++; $display("FAIL rsvd got %h z=%b e=%b want 0 z=1 e=1", got_d[0], got_z[0], got_e[0]); end
            checks++; if ({got_d[1], got_z[1], got_e[1]} !== {32'd0, 2'b10}) begin failures++; $display("FAIL zero_and got %h z=%b e=%b want 0 z=1 e=0", got_d[1], got_z[1], got_e[1]); end
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        send($urandom, 32'hFFFFFFFF, 3'd5, 1'b0);
        send($urandom, 32'hFFFFFFFF, 3'd5, 1'b0);
        in_valid = 1'b0;
        step(); step();
        clear_got();
        reset_n = 1'b0;
        #1;
        checks++; if ({out_valid, in_ready} !== 2'b00) begin failures++; $display("FAIL mid_rst_async got v=%b r=%b want 00", out_valid, in_ready); end
        step();
        checks++; if ({out_valid, out_data, out_zero, out_err} !== 35'd0) begin failures++; $display("FAIL mid_rst_outs got v=%b %h z=%b e=%b want all 0", out_valid, out_data, out_zero, out_err); end
        reset_n = 1'b1;
        step();
        send(32'h4, 32'h0, 3'd6, 1'b1);
        in_valid = 1'b0;
        repeat (6) step();
        checks++;
        if (got_d.size() != 1 || got_d[0] !== 32'h00000004) begin
            failures++; $display("FAIL mid_rst_fresh got n=%0d first=%h want n=1 00000004", got_d.size(), (got_d.size() > 0) ? got_d[0] : 32'hx);
        end
    endtask

    task automatic test_widths();
        logic [7:0]  w8;
        logic [63:0] w64;
        a8  = 8'($urandom); b8 = 8'($urandom);
        a64 = {$urandom, $urandom}; b64 = 64'h0F0F0F0F0F0F0F0F;
        w8  = a8 & b8;
        w64 = a64 & b64;
        v8 = 1'b1; v64 = 1'b1;
        step();
        v8 = 1'b0; v64 = 1'b0;
        checks++; if ({ov8, ov64} !== 2'b00) begin failures++; $display("FAIL w_early got %b want 00", {ov8, ov64}); end
        step();
        checks++; if (ov8 !== 1'b1 || d8 !== w8 || z8 !== (w8 == 8'd0) || e8 !== 1'b0) begin failures++; $display("FAIL w8 got v=%b %h z=%b want v=1 %h z=%b", ov8, d8, z8, w8, (w8 == 8'd0)); end
        checks++; if (ov64 !== 1'b1 || d64 !== w64 || z64 !== (w64 == 64'd0) || e64 !== 1'b0) begin failures++; $display("FAIL w64 got v=%b %h z=%b want v=1 %h z=%b", ov64, d64, z64, w64, (w64 == 64'd0)); end
        step();
    endtask

    initial begin
        in_valid = 0; in_a = 0; in_b = 0; in_op = 0; in_last = 0; out_ready = 1;
        v8 = 0; a8 = 0; b8 = 0; v64 = 0; a64 = 0; b64 = 0;
        m_acc = 0; m_act = 0;
        test_reset();
        test_and();
        test_back_to_back();
        test_acc();
        test_random();
        test_flags();
        test_reset_mid();
        test_widths();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
